// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: conditions the raw RX and modem pad inputs before they
// reach the UART core. Each line is synchronised into clk_i and then passed
// through a stability filter. A line-break detector watches the filtered RX
// line, and rejected RX glitches are counted for line-quality diagnostics.
module uart_rx_frontend #(
  parameter int SyncStages  = 2,
  parameter int FiltLen     = 4,
  parameter int CntWidth    = 20,
  parameter int GlitchWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [CntWidth-1:0]    break_thresh_i,
  input  logic                   rxd_i,
  input  logic                   cts_ni,
  input  logic                   dsr_ni,
  input  logic                   ri_ni,
  input  logic                   cd_ni,
  output logic                   rxd_o,
  output logic                   cts_no,
  output logic                   dsr_no,
  output logic                   ri_no,
  output logic                   cd_no,
  output logic                   break_o,
  output logic                   break_pulse_o,
  output logic [GlitchWidth-1:0] glitch_cnt_o
);

  localparam int NumLines = 5;
  localparam int FcWidth  = $clog2(FiltLen + 1);
  localparam logic [FcWidth-1:0] FcLast = FcWidth'(FiltLen - 1);

  // Line order in every vector: {cd, ri, dsr, cts, rxd}; bit 0 is RX.
  logic [NumLines-1:0] raw_lines;
  logic [NumLines-1:0] sync_q [SyncStages];
  logic [NumLines-1:0] s_lines;
  logic [NumLines-1:0] s_next;
  logic [NumLines-1:0] filt_q;
  logic [NumLines-1:0] out_lines;
  logic [FcWidth-1:0]  fc_q [NumLines];

  logic                rx_glitch;
  logic                break_active;
  logic                break_hit;
  logic [CntWidth-1:0] bc_q;
  logic [CntWidth:0]   bc_plus_one;

  assign raw_lines = {cd_ni, ri_ni, dsr_ni, cts_ni, rxd_i};
  assign s_lines   = sync_q[SyncStages-1];
  // Value the last synchroniser stage takes at the next edge.
  assign s_next    = sync_q[SyncStages-2];

  // Synchroniser chain; resets to the idle-high level of every line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= raw_lines;
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Per-line stability filter; while bypassed the filtered level tracks the
  // synchronised level so re-enabling resumes from what the core already sees.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= '1;
      for (int l = 0; l < NumLines; l++) fc_q[l] <= '0;
    end else if (!en_i) begin
      filt_q <= s_next;
      for (int l = 0; l < NumLines; l++) fc_q[l] <= '0;
    end else begin
      for (int l = 0; l < NumLines; l++) begin
        if (s_lines[l] == filt_q[l]) begin
          fc_q[l] <= '0;
        end else if (fc_q[l] == FcLast) begin
          filt_q[l] <= s_lines[l];
          fc_q[l]   <= '0;
        end else begin
          fc_q[l] <= fc_q[l] + 1'b1;
        end
      end
    end
  end

  assign out_lines = en_i ? filt_q : s_lines;
  assign rxd_o     = out_lines[0];
  assign cts_no    = out_lines[1];
  assign dsr_no    = out_lines[2];
  assign ri_no     = out_lines[3];
  assign cd_no     = out_lines[4];

  // An RX excursion that returned before being accepted is a glitch.
  assign rx_glitch = en_i && (s_lines[0] == filt_q[0]) && (fc_q[0] != '0);

  // Saturating glitch counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      glitch_cnt_o <= '0;
    end else if (clr_i) begin
      glitch_cnt_o <= '0;
    end else if (rx_glitch && (glitch_cnt_o != '1)) begin
      glitch_cnt_o <= glitch_cnt_o + 1'b1;
    end
  end

  assign break_active = en_i && (break_thresh_i != '0);
  // Widened so a saturated counter never wraps into a false threshold match.
  assign bc_plus_one  = {1'b0, bc_q} + 1'b1;
  assign break_hit    = (bc_plus_one == {1'b0, break_thresh_i});

  // Break detector: times the filtered RX low phase and flags the threshold crossing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bc_q          <= '0;
      break_o       <= 1'b0;
      break_pulse_o <= 1'b0;
    end else if (!break_active || filt_q[0]) begin
      bc_q          <= '0;
      break_o       <= 1'b0;
      break_pulse_o <= 1'b0;
    end else begin
      if (bc_q != '1) bc_q <= bc_q + 1'b1;
      if (break_hit) break_o <= 1'b1;
      break_pulse_o <= break_hit && !break_o;
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed vector table, hand-written multi-cycle
// sequences and a randomized run checked against a behavioural model.
module tb_uart_rx_frontend;

  localparam int SyncStages  = 2;
  localparam int FiltLen     = 4;
  localparam int CntWidth    = 20;
  localparam int GlitchWidth = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   clr;
  logic [CntWidth-1:0]    thresh;
  logic                   rxd, cts_n, dsr_n, ri_n, cd_n;
  logic                   rxd_o, cts_no, dsr_no, ri_no, cd_no;
  logic                   break_o, break_pulse_o;
  logic [GlitchWidth-1:0] glitch_cnt;

  logic       sat_rxd, sat_clr;
  logic       sat_rxd_o, sat_cts_no, sat_dsr_no, sat_ri_no, sat_cd_no;
  logic       sat_break, sat_pulse;
  logic [3:0] sat_glitch;

  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  uart_rx_frontend #(
    .SyncStages(SyncStages), .FiltLen(FiltLen), .CntWidth(CntWidth), .GlitchWidth(GlitchWidth)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .break_thresh_i(thresh),
    .rxd_i(rxd), .cts_ni(cts_n), .dsr_ni(dsr_n), .ri_ni(ri_n), .cd_ni(cd_n),
    .rxd_o(rxd_o), .cts_no(cts_no), .dsr_no(dsr_no), .ri_no(ri_no), .cd_no(cd_no),
    .break_o(break_o), .break_pulse_o(break_pulse_o), .glitch_cnt_o(glitch_cnt)
  );

  // Narrow glitch counter instance so saturation is reachable in a short run.
  uart_rx_frontend #(
    .SyncStages(SyncStages), .FiltLen(FiltLen), .CntWidth(CntWidth), .GlitchWidth(4)
  ) sat_dut (
    .clk_i(clk), .rst_i(rst), .en_i(1'b1), .clr_i(sat_clr), .break_thresh_i(20'd0),
    .rxd_i(sat_rxd), .cts_ni(1'b1), .dsr_ni(1'b1), .ri_ni(1'b1), .cd_ni(1'b1),
    .rxd_o(sat_rxd_o), .cts_no(sat_cts_no), .dsr_no(sat_dsr_no), .ri_no(sat_ri_no), .cd_no(sat_cd_no),
    .break_o(sat_break), .break_pulse_o(sat_pulse), .glitch_cnt_o(sat_glitch)
  );

  typedef struct {
    logic       rxd;
    logic [3:0] modem;
    logic       en;
    logic       clr;
    int         cycles;
    logic       exp_rxd;
    logic [3:0] exp_modem;
    int         exp_glitch;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state: raw history for the synchroniser delay, the
  // window of synchronised samples seen since enable, and the visible outputs.
  bit [4:0] raw_q[$];
  bit [4:0] win_q[$];
  bit [4:0] m_out;
  int       m_glitch;
  int       m_low_len;
  bit       m_brk;
  bit       m_pulse;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] m, input logic e, input logic c);
    rxd = r;
    {cd_n, ri_n, dsr_n, cts_n} = m;
    en  = e;
    clr = c;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  function automatic void modelInit();
    raw_q.delete();
    for (int i = 0; i < SyncStages; i++) raw_q.push_front(5'h1F);
    win_q.delete();
    m_out     = 5'h1F;
    m_glitch  = 0;
    m_low_len = 0;
    m_brk     = 0;
    m_pulse   = 0;
  endfunction

  // One clock edge of the reference: a level change is accepted once the
  // synchronised input has differed from the output for FiltLen enabled
  // samples in a row; an RX sample that returns to the output after a
  // differing sample is a glitch; break fires when the low run length
  // equals the threshold.
  function automatic void modelStep(input bit e, input bit c, input int th, input bit [4:0] raw);
    bit [4:0] s_pre;
    bit       inc;
    bit       prev;
    bit       accept;
    s_pre = raw_q[$];
    inc   = 0;
    if (!e || th == 0 || m_out[0]) begin
      m_low_len = 0;
      m_brk     = 0;
      m_pulse   = 0;
    end else begin
      m_low_len++;
      m_pulse = (m_low_len == th) && !m_brk;
      if (m_low_len == th) m_brk = 1;
    end
    if (e) begin
      win_q.push_front(s_pre);
      if (win_q.size() > FiltLen) void'(win_q.pop_back());
      for (int l = 0; l < 5; l++) begin
        prev = (win_q.size() >= 2) ? win_q[1][l] : m_out[l];
        if (l == 0 && s_pre[l] == m_out[l] && prev != m_out[l]) inc = 1;
        accept = (win_q.size() == FiltLen);
        for (int i = 0; i < win_q.size(); i++) if (win_q[i][l] == m_out[l]) accept = 0;
        if (accept) m_out[l] = s_pre[l];
      end
    end else begin
      win_q.delete();
    end
    if (c) m_glitch = 0;
    else if (inc && m_glitch < 65535) m_glitch++;
    raw_q.push_front(raw);
    void'(raw_q.pop_back());
    if (!e) m_out = raw_q[$];
  endfunction

  initial begin
    int fall_at, rise_at, pulse_at, pulses, high_cnt, up_at, brk_fall;
    bit found;
    logic prev;
    logic drv;
    int run_left;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    thresh      = '0;
    sat_rxd     = 1'b1;
    sat_clr     = 1'b0;
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);

    // Directed table: {rxd, {cd,ri,dsr,cts}, en, clr, cycles, exp rxd_o, exp modem, exp glitch}
    tbl.push_back(vec_t'{1'b1, 4'hF, 1'b1, 1'b0, 3, 1'b1, 4'hF, 0});
    tbl.push_back(vec_t'{1'b0, 4'hF, 1'b1, 1'b0, 5, 1'b1, 4'hF, 0});
    tbl.push_back(vec_t'{1'b0, 4'hF, 1'b1, 1'b0, 1, 1'b0, 4'hF, 0});
    tbl.push_back(vec_t'{1'b1, 4'hF, 1'b1, 1'b0, 3, 1'b0, 4'hF, 0});
    tbl.push_back(vec_t'{1'b0, 4'hF, 1'b1, 1'b0, 4, 1'b0, 4'hF, 1});
    tbl.push_back(vec_t'{1'b0, 4'hE, 1'b1, 1'b0, 6, 1'b0, 4'hE, 1});
    tbl.push_back(vec_t'{1'b1, 4'h7, 1'b1, 1'b0, 6, 1'b1, 4'h7, 1});
    tbl.push_back(vec_t'{1'b0, 4'h7, 1'b0, 1'b0, 2, 1'b0, 4'h7, 1});
    tbl.push_back(vec_t'{1'b1, 4'h7, 1'b0, 1'b0, 1, 1'b0, 4'h7, 1});
    tbl.push_back(vec_t'{1'b1, 4'h7, 1'b0, 1'b0, 1, 1'b1, 4'h7, 1});
    tbl.push_back(vec_t'{1'b1, 4'h7, 1'b1, 1'b1, 1, 1'b1, 4'h7, 0});
    tbl.push_back(vec_t'{1'b0, 4'h7, 1'b1, 1'b0, 1, 1'b1, 4'h7, 0});
    tbl.push_back(vec_t'{1'b1, 4'h7, 1'b1, 1'b0, 4, 1'b1, 4'h7, 1});
    tbl.push_back(vec_t'{1'b1, 4'hF, 1'b1, 1'b0, 5, 1'b1, 4'h7, 1});
    tbl.push_back(vec_t'{1'b1, 4'hF, 1'b1, 1'b0, 1, 1'b1, 4'hF, 1});
    tbl.push_back(vec_t'{1'b0, 4'hF, 1'b1, 1'b0, 3, 1'b1, 4'hF, 1});
    tbl.push_back(vec_t'{1'b1, 4'hF, 1'b1, 1'b0, 6, 1'b1, 4'hF, 2});

    // Reset state with idle inputs.
    doReset();
    checkOutput("reset rxd_o", rxd_o, 1'b1);
    checkOutput("reset modem", {cd_no, ri_no, dsr_no, cts_no}, 4'hF);
    checkOutput("reset break_o", break_o, 1'b0);
    checkOutput("reset break_pulse_o", break_pulse_o, 1'b0);
    checkOutput("reset glitch_cnt", glitch_cnt, 0);

    // Table-driven filter, bypass and clear vectors.
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rxd, tbl[i].modem, tbl[i].en, tbl[i].clr);
      tick(tbl[i].cycles);
      checkOutput($sformatf("vec%0d rxd_o", i), rxd_o, tbl[i].exp_rxd);
      checkOutput($sformatf("vec%0d modem", i), {cd_no, ri_no, dsr_no, cts_no}, tbl[i].exp_modem);
      checkOutput($sformatf("vec%0d glitch_cnt", i), glitch_cnt, tbl[i].exp_glitch);
      checkOutput($sformatf("vec%0d break_o", i), break_o, 1'b0);
    end
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);

    // Break detection with a 100-cycle threshold and a 300-cycle low phase.
    thresh = 20'd100;
    doReset();
    rxd = 1'b0;
    fall_at = -1; rise_at = -1; pulse_at = -1; pulses = 0; high_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      tick(1);
      if (fall_at < 0 && !rxd_o) fall_at = k;
      if (break_o) begin
        high_cnt++;
        if (rise_at < 0) rise_at = k;
      end
      if (break_pulse_o) begin
        pulses++;
        pulse_at = k;
      end
    end
    rxd = 1'b1;
    up_at = -1; brk_fall = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (up_at < 0 && rxd_o) up_at = k;
      if (brk_fall < 0 && !break_o) brk_fall = k;
      if (break_pulse_o) pulses++;
    end
    checkOutput("break rxd_o fall cycle", fall_at, 6);
    checkOutput("break_o rise cycle", rise_at, 106);
    checkOutput("break_pulse_o cycle", pulse_at, 106);
    checkOutput("break_pulse_o count", pulses, 1);
    checkOutput("break_o high cycles", high_cnt, 195);
    checkOutput("break rxd_o rise cycle", up_at, 6);
    checkOutput("break_o fall cycle", brk_fall, 7);

    // Bypass: CTS toggling every cycle shows up two edges later.
    en = 1'b0;
    prev = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drv = logic'(i % 2);
      cts_n = drv;
      tick(1);
      checkOutput($sformatf("bypass cts_no step %0d", i), cts_no, prev);
      prev = drv;
    end
    cts_n = 1'b0;
    tick(4);
    en = 1'b1;
    tick(3);
    checkOutput("reenable cts_no", cts_no, 1'b0);
    checkOutput("reenable break_o", break_o, 1'b0);
    cts_n = 1'b1;
    tick(8);

    // Asynchronous reset in the middle of a break.
    doReset();
    rxd = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick(1);
      if (break_o) found = 1;
    end
    checkOutput("break before async reset", found, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset break_o", break_o, 1'b0);
    checkOutput("async reset rxd_o", rxd_o, 1'b1);
    checkOutput("async reset break_pulse_o", break_pulse_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    pulse_at = -1;
    for (int k = 1; k <= 200 && pulse_at < 0; k++) begin
      tick(1);
      if (break_pulse_o) pulse_at = k;
    end
    checkOutput("post reset break_pulse_o cycle", pulse_at, 106);
    rxd = 1'b1;
    thresh = '0;
    tick(10);

    // Glitch counter saturation and clear priority on the narrow instance.
    doReset();
    for (int n = 0; n < 5; n++) begin
      sat_rxd = 1'b0; tick(1);
      sat_rxd = 1'b1; tick(1);
    end
    tick(3);
    checkOutput("sat glitch count 5", sat_glitch, 5);
    for (int n = 0; n < 15; n++) begin
      sat_rxd = 1'b0; tick(1);
      sat_rxd = 1'b1; tick(1);
    end
    tick(3);
    checkOutput("sat glitch saturated", sat_glitch, 15);
    checkOutput("sat rxd_o steady", sat_rxd_o, 1'b1);
    sat_rxd = 1'b0; tick(1);
    sat_rxd = 1'b1; tick(2);
    sat_clr = 1'b1; tick(1);
    sat_clr = 1'b0;
    tick(2);
    checkOutput("sat clear beats increment", sat_glitch, 0);
    sat_rxd = 1'b0; tick(1);
    sat_rxd = 1'b1; tick(3);
    checkOutput("sat glitch after clear", sat_glitch, 1);

    // Randomized run against the behavioural model.
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
    thresh = 20'd20;
    doReset();
    modelInit();
    run_left = 10;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 400 == 0)
        thresh = ($urandom_range(0, 9) == 0) ? '0 : CntWidth'($urandom_range(1, 40));
      if (run_left == 0) begin
        rxd = ~rxd;
        run_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(4, 150);
      end
      run_left--;
      if ($urandom_range(0, 7) == 0) cts_n = ~cts_n;
      if ($urandom_range(0, 7) == 0) dsr_n = ~dsr_n;
      if ($urandom_range(0, 7) == 0) ri_n  = ~ri_n;
      if ($urandom_range(0, 7) == 0) cd_n  = ~cd_n;
      if ($urandom_range(0, 299) == 0) en = ~en;
      clr = ($urandom_range(0, 149) == 0);
      @(posedge clk);
      modelStep(en, clr, int'(thresh), {cd_n, ri_n, dsr_n, cts_n, rxd});
      @(negedge clk);
      checkOutput($sformatf("random cycle %0d", cyc),
                  {break_o, break_pulse_o, cd_no, ri_no, dsr_no, cts_no, rxd_o, glitch_cnt},
                  {m_brk, m_pulse, m_out[4], m_out[3], m_out[2], m_out[1], m_out[0], 16'(m_glitch)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
